// File: rtl/bmp_stream_packer.sv
`timescale 1ns/1ps
// bmp_stream_packer
// Parses a raw BMP byte stream. It captures and validates the 30-byte header,
// drops the bytes between the header and the pixel array, then packs the
// pixel bytes into DATA_WIDTH-bit words for the accelerator slave port.
//
// Handshakes: a byte moves when in_valid && in_ready. A word moves when
// out_valid && out_ready. out_data/out_keep/out_last hold stable while
// out_valid && !out_ready.
//
// Ports
//   clk, rst_n (async, active low), clr (sync soft clear)
//   in_byte/in_valid/in_ready       byte stream input
//   out_data/out_keep/out_last/out_valid/out_ready   packed word output
//   cmplt                           one-cycle pulse after the last word is accepted
//   hdr_valid, file_size, data_offset, img_width, img_height, bit_count
//                                   captured header fields
//   err, err_code                   sticky header error (0 sig, 1 size, 2 offset, 3 bpp)
//   dbg_state                       current FSM state
module bmp_stream_packer #(
   parameter int DATA_WIDTH    = 32,
   parameter int BYTE_ORDER    = 0,
   parameter int MAX_FILE_SIZE = 1000000
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            clr,
   input  logic [7:0]                      in_byte,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic [DATA_WIDTH-1:0]           out_data,
   output logic [$clog2(DATA_WIDTH/8):0]   out_keep,
   output logic                            out_last,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            cmplt,
   output logic                            hdr_valid,
   output logic [31:0]                     file_size,
   output logic [31:0]                     data_offset,
   output logic [31:0]                     img_width,
   output logic [31:0]                     img_height,
   output logic [15:0]                     bit_count,
   output logic                            err,
   output logic [1:0]                      err_code,
   output logic [2:0]                      dbg_state
);

   localparam int BPW = DATA_WIDTH / 8;
   localparam int LW  = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int KW  = $clog2(BPW) + 1;

   typedef enum logic [2:0] {S_HDR, S_SKIP, S_PIXEL, S_FLUSH, S_ERR} state_t;

   typedef struct packed {
      logic [31:0]           bcnt;
      logic [LW-1:0]         lane;
      logic [DATA_WIDTH-1:0] acc;
      logic [DATA_WIDTH-1:0] data;
      logic [KW-1:0]         keep;
      logic                  last;
      logic                  valid;
      logic                  cmplt;
      logic                  hdr_valid;
      logic [7:0]            sig0;
      logic [7:0]            sig1;
      logic [31:0]           file_size;
      logic [31:0]           data_offset;
      logic [31:0]           width;
      logic [31:0]           height;
      logic [15:0]           bit_count;
      logic                  err;
      logic [1:0]            err_code;
   } dp_t;

   state_t state_q, state_d;
   dp_t    dp_q, dp_d;

   logic                  byte_xfer, word_xfer;
   logic                  last_byte, word_done;
   logic [1:0]            hsel;
   logic [15:0]           bc_full;
   logic                  hdr_fail;
   logic [1:0]            hdr_code;
   logic [DATA_WIDTH-1:0] acc_ins;

   assign in_ready  = (state_q == S_HDR) || (state_q == S_SKIP) ||
                      ((state_q == S_PIXEL) && (!dp_q.valid || out_ready));
   assign byte_xfer = in_valid && in_ready;
   assign word_xfer = dp_q.valid && out_ready;
   assign last_byte = (dp_q.bcnt == dp_q.file_size - 32'd1);
   assign word_done = (dp_q.lane == LW'(BPW - 1)) || last_byte;

   // Every multi-byte header field starts at an index that is 2 mod 4, so
   // (index - 2) mod 4 is the little-endian byte position inside the field.
   assign hsel    = dp_q.bcnt[1:0] - 2'd2;
   // bit_count's high byte arrives on the same transfer that runs the checks.
   assign bc_full = {in_byte, dp_q.bit_count[7:0]};

   always_comb begin
      hdr_fail = 1'b1;
      hdr_code = 2'd0;
      if ({dp_q.sig0, dp_q.sig1} != 16'h424D)
         hdr_code = 2'd0;
      else if (dp_q.file_size > 32'(MAX_FILE_SIZE))
         hdr_code = 2'd1;
      else if (dp_q.data_offset < 32'd30 || dp_q.data_offset >= dp_q.file_size)
         hdr_code = 2'd2;
      else if (!(bc_full == 16'd8 || bc_full == 16'd24 || bc_full == 16'd32))
         hdr_code = 2'd3;
      else
         hdr_fail = 1'b0;
   end

   // Drop the incoming byte into its lane. The accumulator is cleared whenever
   // a word completes, so unfilled lanes of a short final word read as zero.
   always_comb begin
      acc_ins = dp_q.acc;
      for (int i = 0; i < BPW; i++) begin
         if (dp_q.lane == LW'(i)) begin
            if (BYTE_ORDER == 0) acc_ins[(BPW-1-i)*8 +: 8] = in_byte;
            else                 acc_ins[i*8 +: 8]         = in_byte;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   state_q <= S_HDR;
      else if (clr) state_q <= S_HDR;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_HDR: begin
            if (byte_xfer && dp_q.bcnt == 32'd29) begin
               if (hdr_fail)                         state_d = S_ERR;
               else if (dp_q.data_offset == 32'd30)  state_d = S_PIXEL;
               else                                  state_d = S_SKIP;
            end
         end
         S_SKIP:  if (byte_xfer && dp_q.bcnt == dp_q.data_offset - 32'd1) state_d = S_PIXEL;
         S_PIXEL: if (byte_xfer && last_byte) state_d = S_FLUSH;
         S_FLUSH: if (word_xfer) state_d = S_HDR;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_HDR;
      endcase
   end

   always_comb begin
      dp_d       = dp_q;
      dp_d.cmplt = 1'b0;
      if (byte_xfer) dp_d.bcnt = dp_q.bcnt + 32'd1;

      if (state_q == S_HDR && byte_xfer) begin
         if (dp_q.bcnt == 32'd0) dp_d.sig0 = in_byte;
         if (dp_q.bcnt == 32'd1) dp_d.sig1 = in_byte;
         if (dp_q.bcnt >= 32'd2 && dp_q.bcnt <= 32'd5)
            dp_d.file_size[{hsel, 3'b000} +: 8] = in_byte;
         if (dp_q.bcnt >= 32'd10 && dp_q.bcnt <= 32'd13)
            dp_d.data_offset[{hsel, 3'b000} +: 8] = in_byte;
         if (dp_q.bcnt >= 32'd18 && dp_q.bcnt <= 32'd21)
            dp_d.width[{hsel, 3'b000} +: 8] = in_byte;
         if (dp_q.bcnt >= 32'd22 && dp_q.bcnt <= 32'd25)
            dp_d.height[{hsel, 3'b000} +: 8] = in_byte;
         if (dp_q.bcnt >= 32'd28 && dp_q.bcnt <= 32'd29)
            dp_d.bit_count[{dp_q.bcnt[0], 3'b000} +: 8] = in_byte;
         if (dp_q.bcnt == 32'd29) begin
            if (hdr_fail) begin
               dp_d.err      = 1'b1;
               dp_d.err_code = hdr_code;
            end else begin
               dp_d.hdr_valid = 1'b1;
            end
         end
      end

      if (word_xfer) dp_d.valid = 1'b0;

      // A completing byte in the same cycle as a word transfer reloads the
      // output register, so valid stays high without a bubble.
      if (state_q == S_PIXEL && byte_xfer) begin
         if (word_done) begin
            dp_d.data  = acc_ins;
            dp_d.keep  = KW'(dp_q.lane) + KW'(1);
            dp_d.last  = last_byte;
            dp_d.valid = 1'b1;
            dp_d.lane  = '0;
            dp_d.acc   = '0;
         end else begin
            dp_d.acc   = acc_ins;
            dp_d.lane  = dp_q.lane + LW'(1);
         end
      end

      if (state_q == S_FLUSH && word_xfer) begin
         dp_d.cmplt     = 1'b1;
         dp_d.bcnt      = 32'd0;
         dp_d.hdr_valid = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   dp_q <= '0;
      else if (clr) dp_q <= '0;
      else          dp_q <= dp_d;
   end

   assign out_data    = dp_q.data;
   assign out_keep    = dp_q.keep;
   assign out_last    = dp_q.last;
   assign out_valid   = dp_q.valid;
   assign cmplt       = dp_q.cmplt;
   assign hdr_valid   = dp_q.hdr_valid;
   assign file_size   = dp_q.file_size;
   assign data_offset = dp_q.data_offset;
   assign img_width   = dp_q.width;
   assign img_height  = dp_q.height;
   assign bit_count   = dp_q.bit_count;
   assign err         = dp_q.err;
   assign err_code    = dp_q.err_code;
   assign dbg_state   = state_q;

endmodule
